// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : packet-level round-robin arbiter sharing one TX FIFO path
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_BIT   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           src_valid,
  input  logic [N_REQ*N_BIT-1:0]     src_data,
  input  logic [N_REQ-1:0]           src_last,
  output logic [N_REQ-1:0]           src_ready,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic [N_BIT-1:0]           tx_wr_data,
  output logic                       tx_wr_en,
  input  logic                       tx_full,
  output logic                       len_err,
  output logic [$clog2(N_REQ)-1:0]   err_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef logic [IW:0] sum_t;
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [IW-1:0]       r_gidx;
  logic [IW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_cnt;
  logic                r_len_err;
  logic [IW-1:0]       r_err_id;

  logic                w_found;
  logic [IW-1:0]       w_pick;
  logic                w_acc;
  logic                w_done;
  logic                w_force;
  logic [IW-1:0]       w_next_rr;
  logic [N_BIT-1:0]    w_data;

  // Scan rr_ptr, rr_ptr+1, ... wrapping at N_REQ; the first set req wins.
  always_comb begin
    sum_t v_sum;
    w_found = 1'b0;
    w_pick  = '0;
    v_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v_sum = {1'b0, r_rr_ptr} + sum_t'(i);
      if (v_sum >= sum_t'(N_REQ)) v_sum = v_sum - sum_t'(N_REQ);
      if (!w_found && req[v_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_sum[IW-1:0];
      end
    end
  end

  assign w_data    = src_data[r_gidx*N_BIT +: N_BIT];
  assign w_acc     = (r_state == S_XFER) && src_valid[r_gidx] && !tx_full;
  assign w_force   = w_acc && !src_last[r_gidx] && (r_cnt == CW'(MAX_LEN - 1));
  assign w_done    = (w_acc && src_last[r_gidx]) || w_force;
  assign w_next_rr = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;

  assign grant      = r_grant;
  assign busy       = (r_state == S_XFER);
  assign src_ready  = (busy && !tx_full) ? r_grant : '0;
  assign tx_wr_en   = w_acc;
  assign tx_wr_data = w_acc ? w_data : '0;
  assign len_err    = r_len_err;
  assign err_id     = r_err_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
      r_err_id  <= '0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_XFER;
            r_grant <= N_REQ'(1) << w_pick;
            r_gidx  <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_XFER: begin
          if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
            // Release on last byte or on the MAX_LEN-th byte, whichever first.
            if (w_done) begin
              r_state  <= S_IDLE;
              r_grant  <= '0;
              r_rr_ptr <= w_next_rr;
            end
            if (w_force) begin
              r_len_err <= 1'b1;
              r_err_id  <= r_gidx;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed, table-driven bench for uart_tx_arbiter
// Revision 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, src_valid, src_last, src_ready, grant;
  logic [31:0] src_data;
  logic        busy, tx_wr_en, tx_full, len_err;
  logic [7:0]  tx_wr_data;
  logic [1:0]  err_id;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter #(.N_REQ(4), .N_BIT(8), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .req(req), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .grant(grant), .busy(busy),
    .tx_wr_data(tx_wr_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
    .len_err(len_err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req, valid, last;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_grant;
    logic        e_busy, e_wen;
    logic [7:0]  e_wdata;
    logic [3:0]  e_ready;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [3:0] r, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                              logic f, logic [3:0] g, logic b, logic w, logic [7:0] wd,
                              logic [3:0] rd);
    vec_t t;
    t.req = r; t.valid = v; t.last = l; t.data = d; t.full = f;
    t.e_grant = g; t.e_busy = b; t.e_wen = w; t.e_wdata = wd; t.e_ready = rd;
    return t;
  endfunction

  function automatic logic [7:0] pbyte(int id, int k);
    return 8'((id << 5) + k + 1);
  endfunction

  // Drives one requester through a packet of nbytes with tx_full raised on
  // XFER cycles st_lo..st_hi of each grant; checks every accepted byte.
  task automatic run_pkt(input int id, input int nbytes, input int st_lo, input int st_hi,
                         output int sent, output int pulses, output int grants);
    int         xcyc, pcnt, forced_cyc, done;
    logic [3:0] own, prev_g;
    logic       full_now, lst;
    sent = 0; pulses = 0; grants = 0; xcyc = 0; pcnt = 0;
    forced_cyc = -10; done = 0; prev_g = '0;
    own = 4'(1 << id);
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (grant == 4'b0) begin xcyc = 0; pcnt = 0; end
      else xcyc++;
      full_now  = (xcyc >= st_lo) && (xcyc <= st_hi);
      lst       = (sent == nbytes - 1);
      req       = (sent < nbytes) ? own : 4'b0;
      src_valid = (sent < nbytes) ? own : 4'b0;
      src_last  = lst ? own : 4'b0;
      src_data  = '0;
      src_data[id*8 +: 8] = pbyte(id, sent);
      tx_full   = full_now;
      @(negedge clk);
      if (grant != 4'b0 && prev_g == 4'b0) grants++;
      prev_g = grant;
      if (grant != 4'b0 && sent < nbytes) begin
        chk("own", 32'(grant), 32'(own));
        chk("ready", 32'(src_ready), full_now ? 32'd0 : 32'(own));
        chk("wen", 32'(tx_wr_en), full_now ? 32'd0 : 32'd1);
      end
      if (tx_wr_en) begin
        chk("byte", 32'(tx_wr_data), 32'(pbyte(id, sent)));
        pcnt++;
        if (pcnt == 16 && !lst) forced_cyc = cyc;
        sent++;
      end
      if (len_err) begin
        pulses++;
        chk("lerr_time", 32'(cyc), 32'(forced_cyc + 1));
        chk("err_id", 32'(err_id), 32'(id));
      end
      if (cyc == forced_cyc + 1) chk("forced_rel", 32'(grant), 32'd0);
      step();
      if (sent == nbytes && grant == 4'b0) done++;
      if (done == 2) break;
    end
    chk("pkt_done", 32'(sent), 32'(nbytes));
    req = '0; src_valid = '0; src_last = '0; src_data = '0; tx_full = 1'b0;
  endtask

  initial begin
    int s, p, g;
    rst = 1'b0; req = '0; src_valid = '0; src_last = '0; src_data = '0; tx_full = 1'b0;

    tbl[0]  = mk(4'h1, 4'h0, 4'h0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    tbl[1]  = mk(4'h1, 4'h1, 4'h0, 32'h000000A5, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 4'h1);
    tbl[2]  = mk(4'h1, 4'h1, 4'h0, 32'h0000005A, 1'b1, 4'h1, 1'b1, 1'b0, 8'h00, 4'h0);
    tbl[3]  = mk(4'h1, 4'h1, 4'h0, 32'h0000005A, 1'b0, 4'h1, 1'b1, 1'b1, 8'h5A, 4'h1);
    tbl[4]  = mk(4'h1, 4'h1, 4'h1, 32'h000000C3, 1'b0, 4'h1, 1'b1, 1'b1, 8'hC3, 4'h1);
    tbl[5]  = mk(4'h0, 4'h0, 4'h0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    tbl[6]  = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    tbl[7]  = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h2, 1'b1, 1'b1, 8'h22, 4'h2);
    tbl[8]  = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    tbl[9]  = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h4, 1'b1, 1'b1, 8'h33, 4'h4);
    tbl[10] = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    tbl[11] = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h8, 1'b1, 1'b1, 8'h44, 4'h8);
    tbl[12] = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    tbl[13] = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h1, 1'b1, 1'b1, 8'h11, 4'h1);
    tbl[14] = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0);
    tbl[15] = mk(4'hF, 4'hF, 4'hF, 32'h44332211, 1'b0, 4'h2, 1'b1, 1'b1, 8'h22, 4'h2);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wen", 32'(tx_wr_en), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_lenerr", 32'(len_err), 32'd0);
    chk("rst_errid", 32'(err_id), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; src_valid = tbl[i].valid; src_last = tbl[i].last;
      src_data = tbl[i].data; tx_full = tbl[i].full;
      @(negedge clk);
      chk($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_wen", i), 32'(tx_wr_en), 32'(tbl[i].e_wen));
      chk($sformatf("row%0d_wdata", i), 32'(tx_wr_data), 32'(tbl[i].e_wdata));
      chk($sformatf("row%0d_ready", i), 32'(src_ready), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d_lenerr", i), 32'(len_err), 32'd0);
      step();
    end
    req = '0; src_valid = '0; src_last = '0; src_data = '0;
    step();

    // Backpressure: requester 2, 4 bytes, FIFO full on XFER cycles 2..5.
    run_pkt(2, 4, 2, 5, s, p, g);
    chk("bp_grants", 32'(g), 32'd1);
    chk("bp_lenerr", 32'(p), 32'd0);

    // Overlong packet: forced release after 16, remaining 4 as a second grant.
    run_pkt(3, 20, 1, 0, s, p, g);
    chk("le_grants", 32'(g), 32'd2);
    chk("le_pulses", 32'(p), 32'd1);

    // Exactly MAX_LEN bytes with last on the final one completes normally.
    run_pkt(0, 16, 1, 0, s, p, g);
    chk("max_grants", 32'(g), 32'd1);
    chk("max_lenerr", 32'(p), 32'd0);
    chk("errid_held", 32'(err_id), 32'd3);

    // Requester 1 drops req mid-packet while requester 0 waits.
    req = 4'b0011; step();
    chk("drop_g0", 32'(grant), 32'h2);
    src_valid = 4'b0010; src_data = 32'h00006100;
    @(negedge clk); chk("drop_b1", 32'(tx_wr_data), 32'h61); step();
    req = 4'b0001; src_valid = 4'b0011; src_data = 32'h000062EE;
    @(negedge clk);
    chk("drop_hold", 32'(grant), 32'h2);
    chk("drop_ready", 32'(src_ready), 32'h2);
    chk("drop_b2", 32'(tx_wr_data), 32'h62);
    step();
    src_valid = 4'b0010; src_last = 4'b0010; src_data = 32'h00006300;
    @(negedge clk); chk("drop_b3", 32'(tx_wr_data), 32'h63); step();
    src_valid = '0; src_last = '0;
    @(negedge clk); chk("drop_gap", 32'(grant), 32'h0); step();
    @(negedge clk); chk("drop_next", 32'(grant), 32'h1);
    src_valid = 4'b0001; src_last = 4'b0001; src_data = 32'h00000070;
    step();
    req = '0; src_valid = '0; src_last = '0; src_data = '0;
    step();

    // Reset mid-packet: rr_ptr is 1 here, so requester 0 winning afterwards
    // shows the pointer was cleared.
    req = 4'b0100; step();
    chk("rm_grant", 32'(grant), 32'h4);
    src_valid = 4'b0100; src_data = 32'h00810000; step();
    src_data = 32'h00820000;
    #2 rst = 1'b0;
    #1;
    chk("rm_grant0", 32'(grant), 32'h0);
    chk("rm_busy0", 32'(busy), 32'h0);
    chk("rm_wen0", 32'(tx_wr_en), 32'h0);
    step();
    req = 4'b0111; src_valid = '0; src_data = '0;
    step();
    rst = 1'b1;
    step();
    chk("rm_restart", 32'(grant), 32'h1);
    src_valid = 4'b0001; src_last = 4'b0001; step();
    req = '0; src_valid = '0; src_last = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one UART transmit path (TX FIFO plus transmitter) between N_REQ byte-stream requesters.
- Grants one requester at a time and forwards its bytes into the TX FIFO write port, throttled by the FIFO full flag.
- A grant is held for a whole packet; the next requester is never interleaved mid-packet.
- Sits between the message producers (command/status/debug sources) and the transmitter top.

Parameters:
N_REQ, 4, number of requesters (2..8)
N_BIT, 8, data width per byte (matches transmitter/FIFO width)
MAX_LEN, 16, maximum bytes per packet before forced release (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
req  input  N_REQ  requester i has a packet pending; level
src_valid  input  N_REQ  requester i presents a valid byte
src_data  input  N_REQ*N_BIT  requester i byte at [i*N_BIT +: N_BIT]
src_last  input  N_REQ  presented byte is the last of the packet
src_ready  output  N_REQ  byte from requester i accepted this cycle when valid&ready
grant  output  N_REQ  one-hot current owner, all-zero when idle
busy  output  1  high while in XFER
tx_wr_data  output  N_BIT  byte to TX FIFO write port
tx_wr_en  output  1  TX FIFO write strobe
tx_full  input  1  TX FIFO full flag
len_err  output  1  one-cycle pulse on forced release
err_id  output  clog2(N_REQ)  index of offending requester, held until next len_err

Behaviour:
- One clock, clk; reset rst is asynchronous and active-low.
- Reset values: state IDLE, grant 0, busy 0, rr_ptr 0, byte count 0, len_err 0, err_id 0. src_ready, tx_wr_en and tx_wr_data are therefore 0.
- States: IDLE and XFER.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
  - Register grant as one-hot for that index, clear the count and go to XFER next cycle. The grant is visible one cycle after req.
  - No req: stay in IDLE.
- XFER, with g = granted index:
  - src_ready[g] = ~tx_full. All other src_ready bits are 0.
  - tx_wr_en = src_valid[g] & ~tx_full. This is combinational with zero latency.
  - tx_wr_data = src_data[g]. It is 0 when tx_wr_en is 0.
  - Accepted beat means src_valid[g] & ~tx_full. On each accepted beat the count increments.
- End of packet: an accepted beat with src_last[g]=1 causes return to IDLE next cycle, grant <= 0, rr_ptr <= (g+1) mod N_REQ.
- Forced release: an accepted beat that is the MAX_LEN-th byte with src_last[g]=0 causes the same return to IDLE as end of packet. In addition:
  - len_err pulses for 1 cycle (registered, the cycle after the beat);
  - err_id <= g.
  - Remaining bytes from that requester are handled as a new packet under normal arbitration.
- A MAX_LEN-th byte with src_last=1 is normal completion, with no error.
- Packet-to-packet gap: at least one IDLE cycle between packets. A requester never gets two consecutive grants while another req is set.
- tx_full high stalls XFER indefinitely; no beat is lost and the count is unchanged.
- req deasserting mid-packet is ignored; the grant holds until last or forced release. req of non-granted requesters has no effect in XFER.
- src_valid with req=0 in IDLE is ignored.
- Reset mid-packet: immediate return to reset values. Bytes already written to the FIFO remain; the partial packet is not recalled.
- Width: count is clog2(MAX_LEN+1) bits and never wraps, because release occurs at MAX_LEN.

Test Plan:
- Single packet: reset, req=0001, requester 0 sends 0xA5,0x5A,0xC3 (last on 0xC3), tx_full=0 -> grant=0001 one cycle after req; tx_wr_en high 3 cycles with data A5,5A,C3; grant=0000 and rr_ptr=1 afterwards.
- Round robin: req=1111 held, every requester sends 1-byte packets -> grant order 0001,0010,0100,1000,0001, with one IDLE cycle between grants.
- Backpressure: requester 2 sends 4 bytes, tx_full=1 for cycles 2-5 of XFER -> src_ready[2]=0 and tx_wr_en=0 during stall; all 4 bytes appear in order; count correct.
- Length error: MAX_LEN=16, requester 3 sends 20 bytes with last on byte 20 -> release after byte 16; len_err pulses once; err_id=3; bytes 17-20 go out as a second granted packet.
- Req drop mid-packet: requester 1 deasserts req after byte 1 of a 3-byte packet while req[0]=1 -> grant stays 0010 until last; then grant 0001.
- Reset mid-packet: assert rst low during byte 2 of 5 -> grant, busy, tx_wr_en go 0 asynchronously; after release rr_ptr=0 and arbitration restarts from requester 0.
